imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Writer side of the instruction-memory interface: receives a byte stream and assembles
//  little-endian 32-bit words, then writes them into IMem through a write port.
//  Holds the CPU in reset (cpu_rst_n low) until the image is fully written.
//  Sits between an external byte source (UART/JTAG/bench) and IMem/PC in the CPU top.
// PARAMETERS
//  DEPTH_WORDS  256  IMem capacity in 32-bit words; max accepted image length
//  BASE_ADDR    0    byte address of the first written word (multiple of 4)
// PORTS
//  CLK        in   1   clock, all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   1-cycle pulse: begin a load; honoured only in IDLE or DONE
//  in_valid   in   1   in_byte carries a byte
//  in_ready   out  1   loader accepts a byte this cycle (transfer = in_valid & in_ready)
//  in_byte    in   8   stream byte
//  imem_we    out  1   1-cycle write strobe to IMem
//  imem_waddr out  32  byte address of the word being written
//  imem_wdata out  32  assembled instruction word
//  cpu_rst_n  out  1   active-low CPU hold; high only in DONE
//  done       out  1   image written successfully
//  err        out  1   length header exceeded DEPTH_WORDS
// BEHAVIOUR
//  Reset (async): state=IDLE; in_ready=0, imem_we=0, imem_waddr=BASE_ADDR,
//   imem_wdata=0, cpu_rst_n=0, done=0, err=0; internal counters cleared.
//  Stream format: LEN_LO, LEN_HI (16-bit word count N), then N*4 bytes, each word LSB first.
//  States / transitions:
//   IDLE : in_ready=0. start -> LEN0.
//   LEN0 : in_ready=1. transfer -> latch N[7:0], -> LEN1.
//   LEN1 : in_ready=1. transfer -> latch N[15:8]; N==0 -> DONE; N>DEPTH_WORDS -> ERR;
//          else -> DATA with byte_cnt=0, word_idx=0.
//   DATA : in_ready=1. transfer -> byte placed in wdata[8*byte_cnt +: 8], byte_cnt++;
//          on 4th byte -> WRITE.
//   WRITE: in_ready=0; imem_we=1 for exactly this cycle,
//          imem_waddr=BASE_ADDR+4*word_idx, imem_wdata=assembled word;
//          word_idx++; word_idx+1==N -> DONE, else -> DATA (byte_cnt=0).
//   DONE : done=1, cpu_rst_n=1, in_ready=0. start -> LEN0 (done=0, cpu_rst_n=0 next cycle).
//   ERR  : err=1, in_ready=0, cpu_rst_n=0. Exit only by rst.
//  Latency: imem_we asserts the cycle after the 4th byte of a word is accepted.
//  Throughput: max 4 bytes per 5 cycles; in_valid gaps simply stall the current state.
//  Bytes are never dropped: in_byte sampled only when in_valid & in_ready.
//  start outside IDLE/DONE ignored; start together with a transfer in DONE: transfer ignored.
//  word_idx width = clog2(DEPTH_WORDS)+1; N==DEPTH_WORDS is legal (fills memory exactly).
//  imem_waddr/wdata hold last written values outside WRITE; imem_we never high outside WRITE.
//  rst mid-load: immediate return to IDLE, partial words discarded, cpu_rst_n=0.
// TESTING
//  Reset, then start; send 02 00, 13 00 00 20, 34 12 00 AC -> we pulses at addr 0x0
//   data 0x20000013, addr 0x4 data 0xAC001234; then done=1, cpu_rst_n=1.
//  Same image with in_valid toggled every other cycle -> identical writes, no lost bytes,
//   in_ready=0 in each WRITE cycle.
//  Header 00 00 -> DONE two transfers after start, no imem_we pulse.
//  DEPTH_WORDS=256, header 01 01 (N=257) -> err=1, in_ready=0, cpu_rst_n=0 until rst;
//   header 00 01 (N=256) -> 256 writes, last addr BASE_ADDR+0x3FC, done=1.
//  Assert rst after 6 bytes of a 2-word image -> all outputs at reset values same cycle;
//   new start + full image -> writes begin again at BASE_ADDR.
//  From DONE, start and a 1-word image 01 00 EF BE AD DE -> cpu_rst_n low during load,
//   write 0xDEADBEEF at BASE_ADDR, done returns high.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and IMem write-port bundle for the boot loader.
// The master side feeds the loader; the slave side is the loader itself.
interface imem_boot_loader_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    modport master (
        output start, in_valid, in_byte,
        input  in_ready, imem_we, imem_waddr, imem_wdata, cpu_rst_n, done, err
    );

    modport slave (
        input  start, in_valid, in_byte,
        output in_ready, imem_we, imem_waddr, imem_wdata, cpu_rst_n, done, err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Assembles a length-prefixed little-endian byte stream into 32-bit words and
// writes them into IMem, holding the CPU in reset until the image is complete.
module imem_boot_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    imem_boot_loader_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]       state_reg;
    logic [7:0]       len_lo_reg;
    logic [15:0]      len_reg;
    logic [1:0]       byte_cnt_reg;
    logic [IDX_W-1:0] word_idx_reg;
    logic [31:0]      waddr_reg;
    logic [31:0]      wdata_reg;
    logic [23:0]      asm_word;
    logic [15:0]      hdr_len;
    logic             xfer;

    assign bus.in_ready   = (state_reg == S_LEN0) || (state_reg == S_LEN1) || (state_reg == S_DATA);
    assign bus.imem_we    = (state_reg == S_WRITE);
    assign bus.done       = (state_reg == S_DONE);
    assign bus.cpu_rst_n  = (state_reg == S_DONE);
    assign bus.err        = (state_reg == S_ERR);
    assign bus.imem_waddr = waddr_reg;
    assign bus.imem_wdata = wdata_reg;

    assign xfer    = bus.in_valid && bus.in_ready;
    assign hdr_len = {bus.in_byte, len_lo_reg};

    // The three low bytes of a word are parked in per-lane registers; the
    // fourth byte goes straight into the output word together with them.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] lane_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_reg <= '0;
            end else if (state_reg == S_DATA && xfer && byte_cnt_reg == 2'(gi)) begin
                lane_reg <= bus.in_byte;
            end
        end
        assign asm_word[8*gi +: 8] = lane_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            len_lo_reg   <= '0;
            len_reg      <= '0;
            byte_cnt_reg <= '0;
            word_idx_reg <= '0;
            waddr_reg    <= BASE_ADDR;
            wdata_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) state_reg <= S_LEN0;
                end
                S_LEN0: begin
                    if (xfer) begin
                        len_lo_reg <= bus.in_byte;
                        state_reg  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        len_reg      <= hdr_len;
                        byte_cnt_reg <= '0;
                        word_idx_reg <= '0;
                        if (hdr_len == 16'd0)
                            state_reg <= S_DONE;
                        else if (hdr_len > 16'(DEPTH_WORDS))
                            state_reg <= S_ERR;
                        else
                            state_reg <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            // Output registers change only here, so they hold
                            // the last written word everywhere outside WRITE.
                            wdata_reg <= {bus.in_byte, asm_word};
                            waddr_reg <= BASE_ADDR + 32'({word_idx_reg, 2'b00});
                            state_reg <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    word_idx_reg <= word_idx_reg + 1'b1;
                    byte_cnt_reg <= '0;
                    if (16'(word_idx_reg) + 16'd1 == len_reg)
                        state_reg <= S_DONE;
                    else
                        state_reg <= S_DATA;
                end
                S_DONE: begin
                    if (bus.start) state_reg <= S_LEN0;
                end
                S_ERR: begin
                    state_reg <= S_ERR;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: expected IMem writes are queued as bytes are
// driven and matched against every imem_we pulse; table plus corner sequences.
module tb_imem_boot_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_boot_loader_if bus ();

    imem_boot_loader #(
        .DEPTH_WORDS(256),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    localparam logic [31:0] BASE = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] n;
        bit          gap;
        logic        exp_done;
        logic        exp_err;
        int          exp_writes;
    } vec_t;

    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_writes = 0;
    int   next_idx = 0;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard side: every write strobe must match the oldest queued write.
    always @(negedge clk) begin : mon
        wr_t e;
        if (rst === 1'b0 && bus.imem_we === 1'b1) begin
            n_writes++;
            check("we_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                check("pending_writes", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("waddr", bus.imem_waddr, e.addr);
                check("wdata", bus.imem_wdata, e.data);
                $display("write addr=0x%08h data=0x%08h (exp 0x%08h/0x%08h)",
                         bus.imem_waddr, bus.imem_wdata, e.addr, e.data);
            end
        end
    end

    task automatic do_reset();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok;
        ok = 1'b0;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", {31'b0, ok}, 32'd1);
    endtask

    task automatic send_header(input logic [15:0] n, input bit gap);
        next_idx = 0;
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        wr_t e;
        e.addr = BASE + 32'(next_idx) * 32'd4;
        e.data = w;
        exp_q.push_back(e);
        next_idx++;
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.done === 1'b1 || bus.err === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  {31'b0, bus.in_ready},  32'd0);
        check({tag, "_imem_we"},   {31'b0, bus.imem_we},   32'd0);
        check({tag, "_waddr"},     bus.imem_waddr,         BASE);
        check({tag, "_wdata"},     bus.imem_wdata,         32'd0);
        check({tag, "_cpu_rst_n"}, {31'b0, bus.cpu_rst_n}, 32'd0);
        check({tag, "_done"},      {31'b0, bus.done},      32'd0);
        check({tag, "_err"},       {31'b0, bus.err},       32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        rst = 1'b1;
        vecs[0] = '{n: 16'd1,   gap: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1};
        vecs[1] = '{n: 16'd3,   gap: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 3};
        vecs[2] = '{n: 16'd0,   gap: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 0};
        vecs[3] = '{n: 16'd257, gap: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
        vecs[4] = '{n: 16'd256, gap: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 256};

        // Reset values
        do_reset();
        check_idle_outputs("reset");

        // Reference two-word image, back-to-back bytes
        w0 = n_writes;
        pulse_start();
        send_header(16'd2, 1'b0);
        send_word(32'h20000013, 1'b0);
        send_word(32'hAC001234, 1'b0);
        wait_end(20);
        check("img_done",      {31'b0, bus.done},      32'd1);
        check("img_cpu_rst_n", {31'b0, bus.cpu_rst_n}, 32'd1);
        check("img_writes",    32'(n_writes - w0),     32'd2);

        // Same image from DONE with in_valid toggling every other cycle
        w0 = n_writes;
        pulse_start();
        check("restart_cpu_rst_n", {31'b0, bus.cpu_rst_n}, 32'd0);
        check("restart_done",      {31'b0, bus.done},      32'd0);
        send_header(16'd2, 1'b1);
        send_word(32'h20000013, 1'b1);
        send_word(32'hAC001234, 1'b1);
        wait_end(20);
        check("gap_done",   {31'b0, bus.done},  32'd1);
        check("gap_writes", 32'(n_writes - w0), 32'd2);

        // From DONE: one-word image, CPU held during load
        w0 = n_writes;
        pulse_start();
        send_header(16'd1, 1'b0);
        check("load_cpu_rst_n", {31'b0, bus.cpu_rst_n}, 32'd0);
        send_word(32'hDEADBEEF, 1'b0);
        wait_end(20);
        check("beef_done",   {31'b0, bus.done},  32'd1);
        check("beef_writes", 32'(n_writes - w0), 32'd1);

        // Table of lengths, including empty, oversize and full-depth images
        foreach (vecs[v]) begin
            do_reset();
            w0 = n_writes;
            pulse_start();
            send_header(vecs[v].n, vecs[v].gap);
            if (vecs[v].n == 16'd0)
                check($sformatf("vec%0d_done_after_hdr", v), {31'b0, bus.done}, 32'd1);
            if (vecs[v].n <= 16'd256)
                for (int k = 0; k < int'(vecs[v].n); k++) send_word($urandom, vecs[v].gap);
            wait_end(50);
            if (vecs[v].exp_err) begin
                repeat (5) @(negedge clk);
                pulse_start();
                @(negedge clk);
            end
            check($sformatf("vec%0d_done", v),      {31'b0, bus.done},      {31'b0, vecs[v].exp_done});
            check($sformatf("vec%0d_err", v),       {31'b0, bus.err},       {31'b0, vecs[v].exp_err});
            check($sformatf("vec%0d_cpu_rst_n", v), {31'b0, bus.cpu_rst_n}, {31'b0, vecs[v].exp_done});
            check($sformatf("vec%0d_in_ready", v),  {31'b0, bus.in_ready},  32'd0);
            check($sformatf("vec%0d_writes", v),    32'(n_writes - w0),     32'(vecs[v].exp_writes));
            check($sformatf("vec%0d_last_addr", v), bus.imem_waddr,
                  (vecs[v].exp_writes > 0) ? BASE + 32'(vecs[v].exp_writes - 1) * 32'd4 : BASE);
            $display("vector %0d: n=%0d gap=%0d done=%0b err=%0b writes=%0d",
                     v, vecs[v].n, vecs[v].gap, bus.done, bus.err, n_writes - w0);
        end

        // Reset in the middle of the second word
        do_reset();
        pulse_start();
        send_header(16'd2, 1'b0);
        send_word(32'h11223344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        w0 = n_writes;
        pulse_start();
        send_header(16'd2, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        send_word(32'h0BADC0DE, 1'b0);
        wait_end(20);
        check("reload_done",   {31'b0, bus.done},  32'd1);
        check("reload_writes", 32'(n_writes - w0), 32'd2);

        @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
